// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared constants, entry type and reset presets for the pointer file
package lut_pkg;

  localparam int LUT_DATA_W = 8;
  localparam int LUT_DEPTH  = 32;
  localparam int LUT_IDX_W  = 5;
  localparam int LUT_STEP   = 1;

  typedef logic [LUT_DATA_W-1:0] lut_entry_t;

  // Preset data-memory base addresses; every other entry starts at zero.
  function automatic int unsigned lut_reset_val(input int idx);
    case (idx)
      0:       return 32'd14;
      1:       return 32'd20;
      2:       return 32'd127;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/lut_ptr_entry.sv
// rtl/lut_ptr_entry.sv - one pointer register with write-over-increment priority
module lut_ptr_entry
  import lut_pkg::*;
#(
  parameter int DATA_W = LUT_DATA_W,
  parameter int STEP   = LUT_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] reset_val,
  input  logic              wr_hit,
  input  logic              inc_hit,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] val_o
);

  logic [DATA_W-1:0] val_d;
  logic [DATA_W-1:0] val_q;

  // A colliding write replaces the entry outright, so the increment is dropped.
  always_comb begin
    val_d = val_q;
    if (wr_hit) begin
      val_d = wr_data;
    end else if (inc_hit) begin
      val_d = val_q + DATA_W'(STEP);
    end
  end

  // Entry register, reloaded with its preset on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= reset_val;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/lut_ptr_file.sv
// rtl/lut_ptr_file.sv - writable pointer file with registered read and post-increment; optional LUT_PTR_WRAP_FLAG_EN adds wrap_o
module lut_ptr_file
  import lut_pkg::*;
#(
  parameter int DATA_W = LUT_DATA_W,
  parameter int DEPTH  = LUT_DEPTH,
  parameter int IDX_W  = LUT_IDX_W,
  parameter int STEP   = LUT_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_inc,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] dm_o,
  output logic              dm_valid
`ifdef LUT_PTR_WRAP_FLAG_EN
  ,
  output logic              wrap_o
`endif
);

  logic [DATA_W-1:0] ent [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  inc_hit;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] dm_d;
  logic [DATA_W-1:0] dm_q;
  logic              dm_valid_d;
  logic              dm_valid_q;

  // Hit decode only covers real entries, so out-of-range indices touch nothing.
  always_comb begin
    wr_hit  = '0;
    inc_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i]  = wr_en && (wr_idx == IDX_W'(i));
      inc_hit[i] = rd_en && rd_inc && (rd_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    lut_ptr_entry #(
      .DATA_W (DATA_W),
      .STEP   (STEP)
    ) u_ent (
      .clk       (clk),
      .reset     (reset),
      .reset_val (DATA_W'(lut_reset_val(g))),
      .wr_hit    (wr_hit[g]),
      .inc_hit   (inc_hit[g]),
      .wr_data   (wr_data),
      .val_o     (ent[g])
    );
  end

  // Read mux; an index past the last entry reads as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_val = ent[i];
      end
    end
  end

  // Output register holds its value when no read is requested.
  always_comb begin
    dm_d       = rd_en ? rd_val : dm_q;
    dm_valid_d = rd_en;
  end

  // Registered read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      dm_q       <= '0;
      dm_valid_q <= 1'b0;
    end else begin
      dm_q       <= dm_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  assign dm_o     = dm_q;
  assign dm_valid = dm_valid_q;

`ifdef LUT_PTR_WRAP_FLAG_EN
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  logic [DATA_W:0] inc_sum;
  logic            rd_in_range;
  logic            wrap_d;
  logic            wrap_q;

  // Carry out of the post-increment, suppressed when a same-index write wins.
  always_comb begin
    inc_sum     = {1'b0, rd_val} + (DATA_W+1)'(STEP);
    rd_in_range = ({1'b0, rd_idx} < DEPTH_L);
    wrap_d      = rd_en && rd_inc && rd_in_range && inc_sum[DATA_W]
                  && !(wr_en && (wr_idx == rd_idx));
  end

  // Wrap flag registered alongside dm_o.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;
`endif

endmodule

// File: tb/tb_lut_ptr_file.sv
// tb/tb_lut_ptr_file.sv - directed self-checking bench for lut_ptr_file (DEPTH=20)
module tb_lut_ptr_file;

  logic       clk;
  logic       reset;
  logic       rd_en;
  logic [4:0] rd_idx;
  logic       rd_inc;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_data;
  logic [7:0] dm_o;
  logic       dm_valid;
`ifdef LUT_PTR_WRAP_FLAG_EN
  logic       wrap_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model [20];

  lut_ptr_file #(
    .DATA_W (8),
    .DEPTH  (20),
    .IDX_W  (5),
    .STEP   (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_inc   (rd_inc),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .dm_o     (dm_o),
    .dm_valid (dm_valid)
`ifdef LUT_PTR_WRAP_FLAG_EN
    ,
    .wrap_o   (wrap_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_wrap(input string tag, input logic exp);
`ifdef LUT_PTR_WRAP_FLAG_EN
    chk(tag, {31'd0, wrap_o}, {31'd0, exp});
`else
    if (exp === 1'bx) $write("");
`endif
  endtask

  task automatic step(input logic rst, input logic re, input logic [4:0] ri, input logic inc,
                      input logic we, input logic [4:0] wi, input logic [7:0] wd);
    reset   = rst;
    rd_en   = re;
    rd_idx  = ri;
    rd_inc  = inc;
    wr_en   = we;
    wr_idx  = wi;
    wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] ri, input logic inc);
    step(1'b0, 1'b1, ri, inc, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  initial begin
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    chk("reset_dm", dm_o, 0);
    chk("reset_valid", dm_valid, 0);
    chk_wrap("reset_wrap", 1'b0);

    // Preset values, one cycle after each request
    rd(5'd0, 1'b0); chk("rd0", dm_o, 14);  chk("rd0_v", dm_valid, 1);
    rd(5'd1, 1'b0); chk("rd1", dm_o, 20);  chk("rd1_v", dm_valid, 1);
    rd(5'd2, 1'b0); chk("rd2", dm_o, 127); chk("rd2_v", dm_valid, 1);
    rd(5'd3, 1'b0); chk("rd3", dm_o, 0);   chk("rd3_v", dm_valid, 1);
    idle();         chk("idle_v", dm_valid, 0); chk("idle_hold", dm_o, 0);

    // Walk entry 1
    rd(5'd1, 1'b1); chk("inc1_a", dm_o, 20);
    rd(5'd1, 1'b1); chk("inc1_b", dm_o, 21);
    rd(5'd1, 1'b1); chk("inc1_c", dm_o, 22);
    rd(5'd1, 1'b0); chk("inc1_d", dm_o, 23);

    // Wrap at 2**DATA_W
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 8'hFF);
    chk("wr2_v", dm_valid, 0); chk("wr2_hold", dm_o, 23);
    rd(5'd2, 1'b1); chk("wrap_a", dm_o, 255); chk_wrap("wrap_a_flag", 1'b1);
    rd(5'd2, 1'b1); chk("wrap_b", dm_o, 0);   chk_wrap("wrap_b_flag", 1'b0);
    rd(5'd2, 1'b0); chk("wrap_c", dm_o, 1);

    // Same-index collision: old value returned, write wins
    step(1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 8'd50);
    chk("coll_old", dm_o, 14); chk_wrap("coll_flag", 1'b0);
    rd(5'd0, 1'b0); chk("coll_new", dm_o, 50);

    // Different indices in the same cycle
    step(1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd4, 8'd7);
    chk("diff_rd", dm_o, 0);
    rd(5'd3, 1'b0); chk("diff_inc", dm_o, 1);
    rd(5'd4, 1'b0); chk("diff_wr", dm_o, 7);

    // rd_inc without rd_en is ignored
    step(1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 8'd0);
    chk("noinc_v", dm_valid, 0);
    rd(5'd4, 1'b0); chk("noinc", dm_o, 7);

    // Out-of-range write/read/increment
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd25, 8'd9);
    rd(5'd25, 1'b1); chk("oor_dm", dm_o, 0); chk("oor_v", dm_valid, 1);
    chk_wrap("oor_flag", 1'b0);

    for (int i = 0; i < 20; i++) model[i] = 8'd0;
    model[0] = 8'd50; model[1] = 8'd23; model[2] = 8'd1;
    model[3] = 8'd1;  model[4] = 8'd7;
    for (int i = 0; i < 20; i++) begin
      rd(5'(i), 1'b0);
      chk($sformatf("sweep%0d", i), dm_o, model[i]);
    end

    // Reset mid-stream drops the write and the read
    step(1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 5'd0, 8'd99);
    chk("mrst_v", dm_valid, 0); chk("mrst_dm", dm_o, 0);
    rd(5'd0, 1'b0); chk("mrst_rd0", dm_o, 14);
    rd(5'd1, 1'b0); chk("mrst_rd1", dm_o, 20);
    rd(5'd2, 1'b0); chk("mrst_rd2", dm_o, 127);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
